// File: rtl/muldiv_sched.sv
// muldiv_sched: HI/LO arithmetic scheduler for EX.
// Accepts one mult/multu/div/divu request, drives the shared multiplier or
// divider from registered operands, stalls EX while the unit works, and
// holds the 64-bit result on the hilo write bus until the pipeline advances.
module muldiv_sched #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        advance,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stallreq,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam int unsigned CW_D = $clog2(DIV_TIMEOUT + 1);
  localparam int unsigned CW_M = $clog2(MUL_LATENCY + 1);
  localparam int unsigned CW   = (CW_D > CW_M) ? CW_D : CW_M;

  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LATENCY);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_signed_q, mul_signed_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          div_signed_q, div_signed_d;
  logic [31:0]   div_a_q, div_a_d;
  logic [31:0]   div_b_q, div_b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic op_is_mul;
  logic op_is_div;
  logic op_signed;
  logic valid_op;

  assign op_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign op_is_div = (req_op == OP_DIV)  || (req_op == OP_DIVU);
  assign op_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
  assign valid_op  = req_valid && (op_is_mul || op_is_div);

  // Next-state and datapath capture; flush overrides every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_signed_d = mul_signed_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_signed_d = div_signed_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_op) begin
            if (op_is_mul) begin
              mul_signed_d = op_signed;
              mul_a_d      = req_a;
              mul_b_d      = req_b;
              cnt_d        = MUL_INIT;
              state_d      = S_MUL_WAIT;
            end else begin
              div_signed_d = op_signed;
              div_a_d      = req_a;
              div_b_d      = req_b;
              cnt_d        = '0;
              if (req_b == '0) begin
                // Divide by zero never reaches the divider.
                hi_d    = req_a;
                lo_d    = '1;
                state_d = S_DONE;
              end else begin
                state_d = S_DIV_WAIT;
              end
            end
          end
        end
        S_MUL_WAIT: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            {hi_d, lo_d} = mul_result;
            state_d      = S_DONE;
          end
        end
        S_DIV_WAIT: begin
          if (div_ready) begin
            {hi_d, lo_d} = div_result;
            cnt_d        = '0;
            state_d      = S_DONE;
          end else if (cnt_q == DIV_LAST) begin
            // Watchdog: a divider that never answers completes with zero.
            hi_d    = '0;
            lo_d    = '0;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          if (advance) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counter, operand and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mul_signed_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      div_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_signed_q <= mul_signed_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      div_signed_q <= div_signed_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  // The accept cycle stalls combinationally; everything else follows state.
  assign stallreq = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT) ||
                    ((state_q == S_IDLE) && valid_op && !flush && resetn);
  assign busy     = (state_q != S_IDLE);
  assign div_start = (state_q == S_DIV_WAIT);
  assign div_annul = (state_q == S_DIV_WAIT) && flush;
  assign hi_we    = (state_q == S_DONE);
  assign lo_we    = (state_q == S_DONE);
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

  assign mul_signed  = mul_signed_q;
  assign mul_ina     = mul_a_q;
  assign mul_inb     = mul_b_q;
  assign div_signed  = div_signed_q;
  assign div_opdata1 = div_a_q;
  assign div_opdata2 = div_b_q;

endmodule
